// File: rtl/clock_alarm_pkg.sv
// Shared constants for the clock/alarm control slice: FSM encoding, field
// select codes, default counter widths and small FSM helpers.
package clock_alarm_pkg;

  typedef logic [2:0] state_t;

  localparam state_t RUN    = 3'd0;
  localparam state_t ADJ_CH = 3'd1;
  localparam state_t ADJ_CM = 3'd2;
  localparam state_t ADJ_AH = 3'd3;
  localparam state_t ADJ_AM = 3'd4;

  localparam logic [1:0] SEL_CLK_HR  = 2'd0;
  localparam logic [1:0] SEL_CLK_MIN = 2'd1;
  localparam logic [1:0] SEL_ALM_HR  = 2'd2;
  localparam logic [1:0] SEL_ALM_MIN = 2'd3;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;

  // Circular walk through the adjust fields; anything unexpected falls back to RUN.
  function automatic state_t adj_step(input state_t s, input logic fwd);
    case (s)
      ADJ_CH:  return fwd ? ADJ_CM : ADJ_AM;
      ADJ_CM:  return fwd ? ADJ_AH : ADJ_CH;
      ADJ_AH:  return fwd ? ADJ_AM : ADJ_CM;
      ADJ_AM:  return fwd ? ADJ_CH : ADJ_AH;
      default: return RUN;
    endcase
  endfunction

  function automatic logic [1:0] state_to_sel(input state_t s);
    case (s)
      ADJ_CM:  return SEL_CLK_MIN;
      ADJ_AH:  return SEL_ALM_HR;
      ADJ_AM:  return SEL_ALM_MIN;
      default: return SEL_CLK_HR;
    endcase
  endfunction

endpackage

// File: rtl/clock_alarm_ctrl_if.sv
// Bundle between the control stage and the buttons / time counters around it.
interface clock_alarm_ctrl_if #(
  parameter int HR_W  = clock_alarm_pkg::HR_W,
  parameter int MIN_W = clock_alarm_pkg::MIN_W
);
  logic             btn_c, btn_l, btn_r, btn_u, btn_d;
  logic             alarm_arm;
  logic [HR_W-1:0]  clk_hh, alm_hh;
  logic [MIN_W-1:0] clk_mm, alm_mm;

  logic             sec_tick;
  logic             clk_hr_up, clk_hr_dn, clk_min_up, clk_min_dn;
  logic             alm_hr_up, alm_hr_dn, alm_min_up, alm_min_dn;
  logic             adj_mode;
  logic [1:0]       sel;
  logic             blink;
  logic             alarm_led;
  logic             buzzer;

  modport slave (
    input  btn_c, btn_l, btn_r, btn_u, btn_d, alarm_arm,
           clk_hh, clk_mm, alm_hh, alm_mm,
    output sec_tick, clk_hr_up, clk_hr_dn, clk_min_up, clk_min_dn,
           alm_hr_up, alm_hr_dn, alm_min_up, alm_min_dn,
           adj_mode, sel, blink, alarm_led, buzzer
  );

  modport master (
    output btn_c, btn_l, btn_r, btn_u, btn_d, alarm_arm,
           clk_hh, clk_mm, alm_hh, alm_mm,
    input  sec_tick, clk_hr_up, clk_hr_dn, clk_min_up, clk_min_dn,
           alm_hr_up, alm_hr_dn, alm_min_up, alm_min_dn,
           adj_mode, sel, blink, alarm_led, buzzer
  );
endinterface

// File: rtl/clock_alarm_ctrl_tick_gen.sv
// Free-running divider; tick is high for the single cycle the count sits at TICK_DIV-1.
module tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_reg <= '0;
    else if (cnt_reg == LAST)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_reg + CNT_W'(1);
  end

  assign tick = (cnt_reg == LAST);
endmodule

// File: rtl/clock_alarm_ctrl.sv
// Mode FSM, adjust strobes and alarm ringing logic in front of the time counters.
module clock_alarm_ctrl #(
  parameter int TICK_DIV = 100000000,
  parameter int HR_W     = clock_alarm_pkg::HR_W,
  parameter int MIN_W    = clock_alarm_pkg::MIN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  clock_alarm_ctrl_if.slave bus
);
  import clock_alarm_pkg::*;

  logic             tick;
  state_t           state_reg, state_next;
  logic [1:0]       sel_reg, sel_next;
  logic             blink_reg;
  logic             ringing_reg, ringing_next;
  logic             match, match_d_reg;
  logic [7:0]       strobe_reg, strobe_next;
  logic             any_btn, consume;
  logic             strobe_req, strobe_dn;
  logic [1:0]       strobe_sel;
  logic [HR_W-1:0]  clk_hh_w, alm_hh_w;
  logic [MIN_W-1:0] clk_mm_w, alm_mm_w;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign clk_hh_w = bus.clk_hh;
  assign clk_mm_w = bus.clk_mm;
  assign alm_hh_w = bus.alm_hh;
  assign alm_mm_w = bus.alm_mm;
  assign match    = bus.alarm_arm && (clk_hh_w == alm_hh_w) && (clk_mm_w == alm_mm_w);

  assign any_btn = bus.btn_c | bus.btn_l | bus.btn_r | bus.btn_u | bus.btn_d;
  // A press that silences the alarm does nothing else.
  assign consume = ringing_reg & any_btn;

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    strobe_req = 1'b0;
    strobe_dn  = 1'b0;
    if (!consume) begin
      if (bus.btn_c)
        state_next = (state_reg == RUN) ? ADJ_CH : RUN;
      else if (state_reg != RUN) begin
        if (bus.btn_r)
          state_next = adj_step(state_reg, 1'b1);
        else if (bus.btn_l)
          state_next = adj_step(state_reg, 1'b0);
        else if (bus.btn_u)
          strobe_req = 1'b1;
        else if (bus.btn_d) begin
          strobe_req = 1'b1;
          strobe_dn  = 1'b1;
        end
      end
    end
    if (state_next != RUN)
      sel_next = state_to_sel(state_next);

    ringing_next = ringing_reg;
    if (!bus.alarm_arm || consume)
      ringing_next = 1'b0;
    else if (match && !match_d_reg && (state_reg == RUN))
      ringing_next = 1'b1;
  end

  assign strobe_sel = state_to_sel(state_reg);

  // Strobe bit index is field*2 + direction (0 = up, 1 = down).
  for (genvar gi = 0; gi < 8; gi++) begin : g_strobe
    assign strobe_next[gi] = strobe_req && (strobe_sel == 2'(gi / 2)) && (strobe_dn == 1'(gi % 2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      sel_reg     <= SEL_CLK_HR;
      blink_reg   <= 1'b0;
      ringing_reg <= 1'b0;
      match_d_reg <= 1'b0;
      strobe_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      sel_reg     <= sel_next;
      blink_reg   <= blink_reg ^ tick;
      ringing_reg <= ringing_next;
      match_d_reg <= match;
      strobe_reg  <= strobe_next;
    end
  end

  assign bus.sec_tick   = tick && (state_reg == RUN);
  assign bus.clk_hr_up  = strobe_reg[0];
  assign bus.clk_hr_dn  = strobe_reg[1];
  assign bus.clk_min_up = strobe_reg[2];
  assign bus.clk_min_dn = strobe_reg[3];
  assign bus.alm_hr_up  = strobe_reg[4];
  assign bus.alm_hr_dn  = strobe_reg[5];
  assign bus.alm_min_up = strobe_reg[6];
  assign bus.alm_min_dn = strobe_reg[7];
  assign bus.adj_mode   = (state_reg != RUN);
  assign bus.sel        = sel_reg;
  assign bus.blink      = blink_reg;
  assign bus.alarm_led  = ringing_reg;
  assign bus.buzzer     = ringing_reg & blink_reg;
endmodule
